// File: rtl/fetch_jump_redirect_pkg.sv
// Shared types and constants for the execute-to-fetch jump redirect path.
package fetch_jump_redirect_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    TLB_WAIT = 2'd2,
    REDIRECT = 2'd3
  } jrd_state_t;

  localparam logic [31:0] FETCH_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam int          FLUSH_CNT_W      = 4;

  function automatic logic [31:0] fetch_align(input logic [31:0] addr);
    return addr & FETCH_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_jump_redirect_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter
  import fetch_jump_redirect_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: clear wins, increment stops at the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_jump_redirect.sv
// Execute-to-fetch jump redirect: flushes the pipe, optionally flushes the TLB, then hands
// the aligned target PC to fetch; also reports branch-predictor outcomes and statistics.
module fetch_jump_redirect
  import fetch_jump_redirect_pkg::*;
#(
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iRESET_SYNC,
  input  logic             iEVENT_HOLD,
  input  logic             iEVENT_END,
  input  logic             iJUMP_VALID,
  input  logic [31:0]      iJUMP_ADDR,
  input  logic             iPREDICT_ENA,
  input  logic             iPREDICT_HIT,
  input  logic             iNORMAL_JUMP_INST,
  input  logic             iTYPE_BRANCH_VALID,
  input  logic             iTYPE_BRANCH_IB_VALID,
  input  logic             iTYPE_SYSREG_IDT_VALID,
  input  logic             iTYPE_SYSREG_PDT_VALID,
  input  logic             iTYPE_SYSREG_PSR_VALID,
  output logic             oBUSY,
  output logic             oPIPE_FLUSH,
  output logic             oTLB_FLUSH_REQ,
  input  logic             iTLB_FLUSH_ACK,
  output logic             oFETCH_PC_SET_VALID,
  output logic [31:0]      oFETCH_PC_SET_ADDR,
  input  logic             iFETCH_PC_SET_ACK,
  output logic             oBPRED_UPDATE_VALID,
  output logic             oBPRED_UPDATE_HIT,
  output logic [CNT_W-1:0] oSTAT_BRANCH_CNT,
  output logic [CNT_W-1:0] oSTAT_MISS_CNT
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_DONE = FLUSH_CNT_W'(0);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_ONE  = FLUSH_CNT_W'(1);

  jrd_state_t             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]            addr_q, addr_d;
  logic                   tlb_need_q, tlb_need_d;
  logic                   busy_q, busy_d;
  logic                   pipe_flush_q, pipe_flush_d;
  logic                   tlb_req_q, tlb_req_d;
  logic                   pc_valid_q, pc_valid_d;
  logic                   bpred_valid_q, bpred_valid_d;
  logic                   bpred_hit_q, bpred_hit_d;
  logic                   abort_s, req_s, bpred_fire_s, branch_inc_s, miss_inc_s;
  logic                   unused_s;

  // A plain branch redirect always arrives with iJUMP_VALID, so its type flag adds nothing.
  assign unused_s = iTYPE_BRANCH_VALID;
  assign abort_s  = iEVENT_HOLD | iEVENT_END;
  assign req_s    = iJUMP_VALID | iTYPE_BRANCH_IB_VALID | iTYPE_SYSREG_IDT_VALID
                  | iTYPE_SYSREG_PDT_VALID | iTYPE_SYSREG_PSR_VALID;

  // redirect FSM next state and request capture
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    addr_d      = addr_q;
    tlb_need_d  = tlb_need_q;
    if (iRESET_SYNC) begin
      state_d     = IDLE;
      flush_cnt_d = FLUSH_DONE;
      addr_d      = 32'h0000_0000;
      tlb_need_d  = 1'b0;
    end else if (abort_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            state_d     = FLUSH;
            flush_cnt_d = FLUSH_LOAD;
            addr_d      = fetch_align(iJUMP_ADDR);
            tlb_need_d  = iTYPE_SYSREG_PDT_VALID | iTYPE_SYSREG_PSR_VALID;
          end else begin
            state_d = IDLE;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == FLUSH_DONE) begin
            state_d = tlb_need_q ? TLB_WAIT : REDIRECT;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_ONE;
          end
        end
        TLB_WAIT: begin
          if (iTLB_FLUSH_ACK) begin
            state_d = REDIRECT;
          end else begin
            state_d = TLB_WAIT;
          end
        end
        REDIRECT: begin
          if (iFETCH_PC_SET_ACK) begin
            state_d = IDLE;
          end else begin
            state_d = REDIRECT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so that they leave registers aligned with it.
  always_comb begin
    busy_d        = (state_d != IDLE);
    pipe_flush_d  = (state_d == FLUSH);
    tlb_req_d     = (state_d == TLB_WAIT);
    pc_valid_d    = (state_d == REDIRECT);
    bpred_fire_s  = ~busy_q & iPREDICT_ENA & ~abort_s & ~iRESET_SYNC;
    bpred_valid_d = bpred_fire_s;
    bpred_hit_d   = bpred_fire_s & iPREDICT_HIT;
    branch_inc_s  = bpred_fire_s & ~iNORMAL_JUMP_INST;
    miss_inc_s    = branch_inc_s & ~iPREDICT_HIT;
  end

  // state and output registers
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q       <= IDLE;
      flush_cnt_q   <= FLUSH_DONE;
      addr_q        <= 32'h0000_0000;
      tlb_need_q    <= 1'b0;
      busy_q        <= 1'b0;
      pipe_flush_q  <= 1'b0;
      tlb_req_q     <= 1'b0;
      pc_valid_q    <= 1'b0;
      bpred_valid_q <= 1'b0;
      bpred_hit_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      addr_q        <= addr_d;
      tlb_need_q    <= tlb_need_d;
      busy_q        <= busy_d;
      pipe_flush_q  <= pipe_flush_d;
      tlb_req_q     <= tlb_req_d;
      pc_valid_q    <= pc_valid_d;
      bpred_valid_q <= bpred_valid_d;
      bpred_hit_q   <= bpred_hit_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .iCLOCK (iCLOCK),
    .inRESET(inRESET),
    .clr_i  (iRESET_SYNC),
    .inc_i  (branch_inc_s),
    .cnt_o  (oSTAT_BRANCH_CNT)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .iCLOCK (iCLOCK),
    .inRESET(inRESET),
    .clr_i  (iRESET_SYNC),
    .inc_i  (miss_inc_s),
    .cnt_o  (oSTAT_MISS_CNT)
  );

  assign oBUSY               = busy_q;
  assign oPIPE_FLUSH         = pipe_flush_q;
  assign oTLB_FLUSH_REQ      = tlb_req_q;
  assign oFETCH_PC_SET_VALID = pc_valid_q;
  assign oFETCH_PC_SET_ADDR  = addr_q;
  assign oBPRED_UPDATE_VALID = bpred_valid_q;
  assign oBPRED_UPDATE_HIT   = bpred_hit_q;

endmodule

// File: tb/tb_fetch_jump_redirect.sv
// Randomized scoreboard bench for fetch_jump_redirect with a transaction-level reference model.
module tb_fetch_jump_redirect;

  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 8;
  localparam int SAT          = (1 << CNT_W) - 1;

  logic             iCLOCK, inRESET, iRESET_SYNC, iEVENT_HOLD, iEVENT_END;
  logic             iJUMP_VALID, iPREDICT_ENA, iPREDICT_HIT, iNORMAL_JUMP_INST;
  logic [31:0]      iJUMP_ADDR;
  logic             iTYPE_BRANCH_VALID, iTYPE_BRANCH_IB_VALID, iTYPE_SYSREG_IDT_VALID;
  logic             iTYPE_SYSREG_PDT_VALID, iTYPE_SYSREG_PSR_VALID;
  logic             oBUSY, oPIPE_FLUSH, oTLB_FLUSH_REQ, iTLB_FLUSH_ACK;
  logic             oFETCH_PC_SET_VALID, iFETCH_PC_SET_ACK;
  logic [31:0]      oFETCH_PC_SET_ADDR;
  logic             oBPRED_UPDATE_VALID, oBPRED_UPDATE_HIT;
  logic [CNT_W-1:0] oSTAT_BRANCH_CNT, oSTAT_MISS_CNT;

  fetch_jump_redirect #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iEVENT_HOLD(iEVENT_HOLD), .iEVENT_END(iEVENT_END),
    .iJUMP_VALID(iJUMP_VALID), .iJUMP_ADDR(iJUMP_ADDR),
    .iPREDICT_ENA(iPREDICT_ENA), .iPREDICT_HIT(iPREDICT_HIT),
    .iNORMAL_JUMP_INST(iNORMAL_JUMP_INST), .iTYPE_BRANCH_VALID(iTYPE_BRANCH_VALID),
    .iTYPE_BRANCH_IB_VALID(iTYPE_BRANCH_IB_VALID),
    .iTYPE_SYSREG_IDT_VALID(iTYPE_SYSREG_IDT_VALID),
    .iTYPE_SYSREG_PDT_VALID(iTYPE_SYSREG_PDT_VALID),
    .iTYPE_SYSREG_PSR_VALID(iTYPE_SYSREG_PSR_VALID),
    .oBUSY(oBUSY), .oPIPE_FLUSH(oPIPE_FLUSH),
    .oTLB_FLUSH_REQ(oTLB_FLUSH_REQ), .iTLB_FLUSH_ACK(iTLB_FLUSH_ACK),
    .oFETCH_PC_SET_VALID(oFETCH_PC_SET_VALID), .oFETCH_PC_SET_ADDR(oFETCH_PC_SET_ADDR),
    .iFETCH_PC_SET_ACK(iFETCH_PC_SET_ACK),
    .oBPRED_UPDATE_VALID(oBPRED_UPDATE_VALID), .oBPRED_UPDATE_HIT(oBPRED_UPDATE_HIT),
    .oSTAT_BRANCH_CNT(oSTAT_BRANCH_CNT), .oSTAT_MISS_CNT(oSTAT_MISS_CNT)
  );

  typedef struct packed { logic [31:0] addr; logic tlb; } redir_t;

  redir_t redir_q[$];
  logic   bpred_q[$];
  int     checks = 0;
  int     errors = 0;
  int     model_branch = 0;
  int     model_miss = 0;
  int     tlb_delay = 255;
  int     pc_delay = 0;
  bit     ack_noise = 1'b0;

  initial begin
    iCLOCK = 1'b0;
    forever #5 iCLOCK = ~iCLOCK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    iJUMP_VALID = 1'b0; iJUMP_ADDR = 32'h0; iPREDICT_ENA = 1'b0; iPREDICT_HIT = 1'b0;
    iNORMAL_JUMP_INST = 1'b0; iTYPE_BRANCH_VALID = 1'b0; iTYPE_BRANCH_IB_VALID = 1'b0;
    iTYPE_SYSREG_IDT_VALID = 1'b0; iTYPE_SYSREG_PDT_VALID = 1'b0;
    iTYPE_SYSREG_PSR_VALID = 1'b0;
  endtask

  // Present one execute entry while the redirect unit is idle and record what must follow.
  task automatic drive_entry(input logic jv, input logic ib, input logic br, input logic idt,
                             input logic pdt, input logic psr, input logic [31:0] addr,
                             input logic pe, input logic ph, input logic nj);
    iJUMP_VALID = jv; iTYPE_BRANCH_IB_VALID = ib; iTYPE_BRANCH_VALID = br;
    iTYPE_SYSREG_IDT_VALID = idt; iTYPE_SYSREG_PDT_VALID = pdt; iTYPE_SYSREG_PSR_VALID = psr;
    iJUMP_ADDR = addr; iPREDICT_ENA = pe; iPREDICT_HIT = ph; iNORMAL_JUMP_INST = nj;
    if (jv | ib | idt | pdt | psr) redir_q.push_back('{addr: {addr[31:2], 2'b00}, tlb: pdt | psr});
    if (pe) begin
      bpred_q.push_back(ph);
      if (!nj) begin
        if (model_branch < SAT) model_branch++;
        if (!ph && model_miss < SAT) model_miss++;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge iCLOCK);
    while (oBUSY && n < budget) begin
      @(negedge iCLOCK);
      n++;
    end
    if (oBUSY) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_branch_cnt"}, 64'(oSTAT_BRANCH_CNT), 64'(model_branch));
    check({tag, "_miss_cnt"}, 64'(oSTAT_MISS_CNT), 64'(model_miss));
  endtask

  // TLB responder: ack tlb_delay cycles after the request first appears
  initial begin : tlb_resp
    int n;
    n = 0;
    iTLB_FLUSH_ACK = 1'b0;
    forever begin
      @(negedge iCLOCK);
      if (oTLB_FLUSH_REQ) begin
        iTLB_FLUSH_ACK = (n >= tlb_delay);
        n++;
      end else begin
        iTLB_FLUSH_ACK = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        n = 0;
      end
    end
  end

  // fetch responder: ack pc_delay cycles after the new PC first appears
  initial begin : pc_resp
    int k;
    k = 0;
    iFETCH_PC_SET_ACK = 1'b0;
    forever begin
      @(negedge iCLOCK);
      if (oFETCH_PC_SET_VALID) begin
        iFETCH_PC_SET_ACK = (k >= pc_delay);
        k++;
      end else begin
        iFETCH_PC_SET_ACK = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        k = 0;
      end
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a redirect or predictor pulse
  initial begin : monitor
    int          flush_run;
    bit          tlb_seen, prev_flush, prev_valid;
    logic [31:0] cur_addr;
    redir_t      e;
    logic        exp_hit;
    flush_run = 0; tlb_seen = 1'b0; prev_flush = 1'b0; prev_valid = 1'b0; cur_addr = 32'h0;
    forever begin
      @(negedge iCLOCK);
      if (oPIPE_FLUSH) begin
        if (!prev_flush) begin
          flush_run = 0;
          tlb_seen  = 1'b0;
        end
        flush_run++;
      end else if (prev_flush) begin
        check("flush_len", 64'(flush_run), 64'(FLUSH_CYCLES));
      end
      if (oTLB_FLUSH_REQ) tlb_seen = 1'b1;
      if (oFETCH_PC_SET_VALID && !prev_valid) begin
        if (redir_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL redir_unexpected: got addr 0x%0h, required no redirect", oFETCH_PC_SET_ADDR);
        end else begin
          e = redir_q.pop_front();
          cur_addr = e.addr;
          check("redir_addr", 64'(oFETCH_PC_SET_ADDR), 64'(e.addr));
          check("redir_tlb_flush", 64'(tlb_seen), 64'(e.tlb));
        end
      end else if (oFETCH_PC_SET_VALID) begin
        check("redir_addr_stable", 64'(oFETCH_PC_SET_ADDR), 64'(cur_addr));
      end
      if (oBPRED_UPDATE_VALID) begin
        if (bpred_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL bpred_unexpected: got pulse hit=%0d, required no pulse", oBPRED_UPDATE_HIT);
        end else begin
          exp_hit = bpred_q.pop_front();
          check("bpred_hit", 64'(oBPRED_UPDATE_HIT), 64'(exp_hit));
        end
      end
      prev_flush = oPIPE_FLUSH;
      prev_valid = oFETCH_PC_SET_VALID;
    end
  end

  initial begin : main
    int          n, cnt;
    logic [31:0] rnd, addr3;
    inRESET = 1'b0; iRESET_SYNC = 1'b0; iEVENT_HOLD = 1'b0; iEVENT_END = 1'b0;
    clear_inputs();
    repeat (3) @(negedge iCLOCK);
    check("reset_busy", 64'(oBUSY), 64'd0);
    check("reset_flush", 64'(oPIPE_FLUSH), 64'd0);
    check("reset_tlb_req", 64'(oTLB_FLUSH_REQ), 64'd0);
    check("reset_pc_valid", 64'(oFETCH_PC_SET_VALID), 64'd0);
    check("reset_bpred", 64'(oBPRED_UPDATE_VALID), 64'd0);
    check_stats("reset");
    inRESET = 1'b1;
    @(negedge iCLOCK);

    // miss jump to an unaligned target, TLB never acks (must not be needed)
    tlb_delay = 255; pc_delay = 0;
    drive_entry(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1006, 1'b0, 1'b0, 1'b0);
    @(negedge iCLOCK);
    clear_inputs();
    cnt = 0; n = 0;
    while (oBUSY && n < 50) begin cnt++; n++; @(negedge iCLOCK); end
    check("miss_busy_cycles", 64'(cnt), 64'(FLUSH_CYCLES + 1));

    // PDT write: TLB acks 5 cycles after its request
    tlb_delay = 5; pc_delay = 2;
    drive_entry(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    @(negedge iCLOCK);
    clear_inputs();
    cnt = 0; n = 0;
    while (oBUSY && n < 50) begin
      if (oTLB_FLUSH_REQ) cnt++;
      n++;
      @(negedge iCLOCK);
    end
    check("pdt_tlb_req_cycles", 64'(cnt), 64'd6);

    // EVENT_HOLD in TLB_WAIT with the request still presented
    tlb_delay = 255; pc_delay = 0;
    addr3 = 32'h1234_567B;
    drive_entry(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, addr3, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin @(negedge iCLOCK); n++; end while (!oTLB_FLUSH_REQ && n < 20);
    check("abort_reached_tlb_wait", 64'(oTLB_FLUSH_REQ), 64'd1);
    iEVENT_HOLD = 1'b1;
    void'(redir_q.pop_back());
    @(negedge iCLOCK);
    iEVENT_HOLD = 1'b0;
    check("abort_tlb_req", 64'(oTLB_FLUSH_REQ), 64'd0);
    check("abort_busy", 64'(oBUSY), 64'd0);
    check("abort_pc_valid", 64'(oFETCH_PC_SET_VALID), 64'd0);
    redir_q.push_back('{addr: 32'h1234_5678, tlb: 1'b1});
    tlb_delay = 1;
    @(negedge iCLOCK);
    clear_inputs();
    check("reaccept_busy", 64'(oBUSY), 64'd1);
    wait_idle(50);

    // EVENT_END on an idle cycle blocks both the accept and the predictor update
    iJUMP_VALID = 1'b1; iJUMP_ADDR = 32'h0000_2000; iPREDICT_ENA = 1'b1; iEVENT_END = 1'b1;
    @(negedge iCLOCK);
    clear_inputs(); iEVENT_END = 1'b0;
    check("end_no_accept", 64'(oBUSY), 64'd0);

    // prediction held for the whole busy window is consumed once
    pc_delay = 0;
    drive_entry(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4440, 1'b1, 1'b0, 1'b0);
    @(negedge iCLOCK);
    iJUMP_VALID = 1'b0; iTYPE_BRANCH_VALID = 1'b0;
    cnt = 0; n = 0;
    while (oBUSY && n < 50) begin cnt++; n++; @(negedge iCLOCK); end
    iPREDICT_ENA = 1'b0;
    check("held_predict_busy_cycles", 64'(cnt), 64'd4);
    repeat (2) @(negedge iCLOCK);
    check_stats("held_predict");

    // randomized traffic; entries presented while busy must be ignored
    ack_noise = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge iCLOCK);
      tlb_delay = $urandom_range(0, 3);
      pc_delay  = $urandom_range(0, 3);
      rnd = $urandom;
      if (!oBUSY) begin
        drive_entry(rnd[0] & rnd[1], rnd[2] & rnd[3], rnd[4], rnd[5] & rnd[6] & rnd[7],
                    rnd[8] & rnd[9] & rnd[10], rnd[11] & rnd[12] & rnd[13], $urandom,
                    rnd[14], rnd[15], rnd[16] & rnd[17]);
      end else begin
        iJUMP_VALID = rnd[0]; iTYPE_BRANCH_IB_VALID = rnd[1]; iTYPE_SYSREG_PDT_VALID = rnd[2];
        iJUMP_ADDR = $urandom; iPREDICT_ENA = rnd[3]; iPREDICT_HIT = rnd[4];
        iNORMAL_JUMP_INST = rnd[5];
      end
    end
    @(negedge iCLOCK);
    clear_inputs();
    ack_noise = 1'b0;
    wait_idle(100);
    repeat (2) @(negedge iCLOCK);
    check_stats("random");

    // synchronous reset clears the statistics
    iRESET_SYNC = 1'b1;
    @(negedge iCLOCK);
    iRESET_SYNC = 1'b0;
    model_branch = 0; model_miss = 0;
    check_stats("sync_reset");

    // saturation: more mispredicted branches than the counters can hold
    for (int c = 0; c < SAT + 20; c++) begin
      drive_entry(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge iCLOCK);
    end
    clear_inputs();
    repeat (2) @(negedge iCLOCK);
    check_stats("saturate");
    check("saturate_miss_max", 64'(oSTAT_MISS_CNT), 64'(SAT));

    // asynchronous reset while a redirect waits for fetch
    pc_delay = 255;
    drive_entry(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFE_0010, 1'b0, 1'b0, 1'b0);
    @(negedge iCLOCK);
    clear_inputs();
    n = 0;
    while (!oFETCH_PC_SET_VALID && n < 20) begin @(negedge iCLOCK); n++; end
    check("async_reached_redirect", 64'(oFETCH_PC_SET_VALID), 64'd1);
    #2 inRESET = 1'b0;
    #1;
    model_branch = 0; model_miss = 0;
    check("async_pc_valid", 64'(oFETCH_PC_SET_VALID), 64'd0);
    check("async_pc_addr", 64'(oFETCH_PC_SET_ADDR), 64'd0);
    check("async_busy", 64'(oBUSY), 64'd0);
    check_stats("async_reset");
    @(negedge iCLOCK);
    inRESET = 1'b1;
    pc_delay = 1;
    @(negedge iCLOCK);
    drive_entry(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0FFF, 1'b1, 1'b1, 1'b0);
    @(negedge iCLOCK);
    clear_inputs();
    wait_idle(50);
    repeat (2) @(negedge iCLOCK);
    check_stats("post_reset");

    check("redir_queue_drained", 64'(redir_q.size()), 64'd0);
    check("bpred_queue_drained", 64'(bpred_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
